// File: rtl/vec_pkg.sv
// Shared vector-pipeline types: default geometry, lane sequencer state and micro-op record.
package vec_pkg;

  localparam int unsigned VLEN_MAX   = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned VL_W       = $clog2(VLEN_MAX + 1);
  localparam int unsigned ELEM_W     = $clog2(VLEN_MAX);

  typedef enum logic [0:0] {
    IDLE,
    ISSUE
  } lane_seq_state_e;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [REG_ADDR_W-1:0] vd;
    logic [REG_ADDR_W-1:0] vs1;
    logic [REG_ADDR_W-1:0] vs2;
    logic [ELEM_W-1:0]     elem;
    logic [ELEM_W-1:0]     lidx;
    logic                  we;
    logic                  last;
  } lane_uop_t;

endpackage

// File: rtl/lane_seq.sv
// Per-lane element sequencer: expands one vector instruction into this lane's element micro-ops.
// Optional per-element masking is built when VEC_MASK_EN is defined.
module lane_seq #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned LANE_ID    = 0,
  parameter int unsigned VLEN_MAX   = vec_pkg::VLEN_MAX,
  parameter int unsigned REG_ADDR_W = vec_pkg::REG_ADDR_W,
  parameter int unsigned OP_W       = vec_pkg::OP_W,
  localparam int unsigned VL_W      = $clog2(VLEN_MAX + 1),
  localparam int unsigned ELEM_W    = $clog2(VLEN_MAX)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic [REG_ADDR_W-1:0] in_vd,
  input  logic [REG_ADDR_W-1:0] in_vs1,
  input  logic [REG_ADDR_W-1:0] in_vs2,
  input  logic [VL_W-1:0]       in_vl,
`ifdef VEC_MASK_EN
  input  logic                  in_vm,
  input  logic [VLEN_MAX-1:0]   in_mask,
`endif
  output logic                  uop_valid,
  input  logic                  uop_ready,
  output logic [OP_W-1:0]       uop_op,
  output logic [REG_ADDR_W-1:0] uop_vd,
  output logic [REG_ADDR_W-1:0] uop_vs1,
  output logic [REG_ADDR_W-1:0] uop_vs2,
  output logic [ELEM_W-1:0]     uop_elem,
  output logic [ELEM_W-1:0]     uop_lidx,
  output logic                  uop_we,
  output logic                  uop_last,
  output logic                  done
);

  import vec_pkg::*;

  lane_seq_state_e       r_state;
  logic [VL_W-1:0]       r_vl;
  logic [ELEM_W-1:0]     r_elem;
  logic [ELEM_W-1:0]     r_lidx;
  logic [OP_W-1:0]       r_op;
  logic [REG_ADDR_W-1:0] r_vd;
  logic [REG_ADDR_W-1:0] r_vs1;
  logic [REG_ADDR_W-1:0] r_vs2;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_done;

  logic [VL_W-1:0]   w_vl_clamp;
  logic [VL_W:0]     w_first_end;
  logic [VL_W:0]     w_next_end;
  logic              w_has_elems;
  logic [ELEM_W-1:0] w_elem_nxt;
  logic              w_hs;

  assign w_vl_clamp  = (in_vl > VL_W'(VLEN_MAX)) ? VL_W'(VLEN_MAX) : in_vl;
  assign w_has_elems = {1'b0, w_vl_clamp} > (VL_W+1)'(LANE_ID);
  // End-of-instruction compares run one bit wider than vl so elem + stride never wraps.
  assign w_first_end = (VL_W+1)'(LANE_ID + NUM_LANES);
  assign w_next_end  = (VL_W+1)'(r_elem) + (VL_W+1)'(2 * NUM_LANES);
  assign w_elem_nxt  = r_elem + ELEM_W'(NUM_LANES);
  assign w_hs        = r_valid & uop_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
      r_elem  <= '0;
      r_lidx  <= '0;
      r_vl    <= '0;
      r_op    <= '0;
      r_vd    <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_vd  <= in_vd;
            r_vs1 <= in_vs1;
            r_vs2 <= in_vs2;
            r_vl  <= w_vl_clamp;
            if (w_has_elems) begin
              r_state <= ISSUE;
              r_valid <= 1'b1;
              r_elem  <= ELEM_W'(LANE_ID);
              r_lidx  <= '0;
              r_last  <= w_first_end >= {1'b0, w_vl_clamp};
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_hs) begin
            r_elem <= w_elem_nxt;
            r_lidx <= r_lidx + ELEM_W'(1);
            r_last <= w_next_end >= {1'b0, r_vl};
            if (r_last) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef VEC_MASK_EN
  logic                r_vm;
  logic [VLEN_MAX-1:0] r_mask;
  logic                r_we;

  // Write enable is looked up one element ahead so it is registered alongside elem.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vm   <= 1'b0;
      r_mask <= '0;
      r_we   <= 1'b0;
    end else if ((r_state == IDLE) && in_valid) begin
      r_vm   <= in_vm;
      r_mask <= in_mask;
      r_we   <= in_vm | in_mask[LANE_ID];
    end else if (w_hs) begin
      r_we   <= r_vm | r_mask[w_elem_nxt];
    end
  end

  assign uop_we = r_we;
`else
  assign uop_we = 1'b1;
`endif

  assign in_ready  = (r_state == IDLE);
  assign uop_valid = r_valid;
  assign uop_op    = r_op;
  assign uop_vd    = r_vd;
  assign uop_vs1   = r_vs1;
  assign uop_vs2   = r_vs2;
  assign uop_elem  = r_elem;
  assign uop_lidx  = r_lidx;
  assign uop_last  = r_last;
  assign done      = r_done;

endmodule

// File: tb/tb_lane_seq.sv
// Self-checking bench for lane_seq (NUM_LANES=4, LANE_ID=1); mask cases active with VEC_MASK_EN.
module tb_lane_seq;
  import vec_pkg::*;

  localparam int unsigned NL  = 4;
  localparam int unsigned LID = 1;
`ifdef VEC_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W-1:0]       in_op;
  logic [REG_ADDR_W-1:0] in_vd, in_vs1, in_vs2;
  logic [VL_W-1:0]       in_vl;
`ifdef VEC_MASK_EN
  logic                  in_vm;
  logic [VLEN_MAX-1:0]   in_mask;
`endif
  logic                  uop_valid;
  logic                  uop_ready;
  logic [OP_W-1:0]       uop_op;
  logic [REG_ADDR_W-1:0] uop_vd, uop_vs1, uop_vs2;
  logic [ELEM_W-1:0]     uop_elem, uop_lidx;
  logic                  uop_we, uop_last, done;

  lane_seq #(
    .NUM_LANES(NL),
    .LANE_ID  (LID)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_vd    (in_vd),
    .in_vs1   (in_vs1),
    .in_vs2   (in_vs2),
    .in_vl    (in_vl),
`ifdef VEC_MASK_EN
    .in_vm    (in_vm),
    .in_mask  (in_mask),
`endif
    .uop_valid(uop_valid),
    .uop_ready(uop_ready),
    .uop_op   (uop_op),
    .uop_vd   (uop_vd),
    .uop_vs1  (uop_vs1),
    .uop_vs2  (uop_vs2),
    .uop_elem (uop_elem),
    .uop_lidx (uop_lidx),
    .uop_we   (uop_we),
    .uop_last (uop_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Elements owned by LANE_ID below the clamped length: e = LID, LID+NL, ...
  function automatic int exp_count(input int vl);
    int c;
    c = (vl > int'(VLEN_MAX)) ? int'(VLEN_MAX) : vl;
    return (c > int'(LID)) ? (c - int'(LID) - 1) / int'(NL) + 1 : 0;
  endfunction

  // Issue one instruction and check every cycle of its expansion against a list
  // built directly from the ownership/ordering rules.
  task automatic run_instr(input int vl, input bit vm, input logic [63:0] mask,
                           input int stall_pct, input logic [31:0] hold_pat,
                           output int n_uops, output int last_elem);
    lane_uop_t exp_q[$];
    lane_uop_t u;
    lane_uop_t got;
    int        clamp;
    bit        fin;
    n_uops    = 0;
    last_elem = -1;
    u.op  = OP_W'($urandom);
    u.vd  = REG_ADDR_W'($urandom);
    u.vs1 = REG_ADDR_W'($urandom);
    u.vs2 = REG_ADDR_W'($urandom);
    clamp = (vl > int'(VLEN_MAX)) ? int'(VLEN_MAX) : vl;
    for (int e = 0; e < clamp; e++) begin
      if (e % int'(NL) == int'(LID)) begin
        u.elem = ELEM_W'(e);
        u.lidx = ELEM_W'(e / int'(NL));
        u.we   = MASK_EN ? (vm | mask[e]) : 1'b1;
        u.last = 1'b0;
        exp_q.push_back(u);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;

    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_op    = u.op;
    in_vd    = u.vd;
    in_vs1   = u.vs1;
    in_vs2   = u.vs2;
    in_vl    = VL_W'(vl);
`ifdef VEC_MASK_EN
    in_vm    = vm;
    in_mask  = mask;
`endif
    step();
    in_valid = 1'b0;
    in_op    = OP_W'($urandom);
    in_vd    = REG_ADDR_W'($urandom);
    in_vl    = VL_W'($urandom);
    fin      = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (exp_q.size() == 0) begin
        check("zero_elem_done", done, 1);
        check("zero_elem_valid", uop_valid, 0);
        check("zero_elem_in_ready", in_ready, 1);
        fin = 1'b1;
      end else begin
        check("uop_valid", uop_valid, 1);
        check("in_ready_busy", in_ready, 0);
        check("done_busy", done, 0);
        got.op   = uop_op;
        got.vd   = uop_vd;
        got.vs1  = uop_vs1;
        got.vs2  = uop_vs2;
        got.elem = uop_elem;
        got.lidx = uop_lidx;
        got.we   = uop_we;
        got.last = uop_last;
        check("uop_fields", got, exp_q[0]);
        uop_ready = !(cyc < 32 && hold_pat[cyc]) && ($urandom_range(99) >= stall_pct);
        if (uop_ready && uop_valid) begin
          n_uops++;
          last_elem = int'(uop_elem);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            step();
            uop_ready = 1'b0;
            check("done_after_last", done, 1);
            check("in_ready_after_last", in_ready, 1);
            check("valid_after_last", uop_valid, 0);
            fin = 1'b1;
          end
        end
      end
      if (!fin) step();
    end
    if (!fin) check("instr_timeout", 0, 1);
    uop_ready = 1'b0;
    step();
    check("done_one_cycle", done, 0);
  endtask

  typedef struct {
    int          vl;
    bit          vm;
    logic [63:0] mask;
    int          stall;
    logic [31:0] hold;
    int          exp_n;
    int          exp_last;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   n, last;

    reset     = 1'b1;
    in_valid  = 1'b0;
    uop_ready = 1'b0;
    in_op     = '0;
    in_vd     = '0;
    in_vs1    = '0;
    in_vs2    = '0;
    in_vl     = '0;
`ifdef VEC_MASK_EN
    in_vm     = 1'b0;
    in_mask   = '0;
`endif
    repeat (3) step();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_uop_valid", uop_valid, 0);
    check("rst_done", done, 0);
    check("rst_elem", uop_elem, 0);
    check("rst_lidx", uop_lidx, 0);
    check("rst_op", uop_op, 0);
    check("rst_vd", uop_vd, 0);
    check("rst_last", uop_last, 0);

    // vl=8 with hold: elem 1 accepted at T+1, elem 5 stalled at T+2..T+4.
    tbl.push_back('{10,  1'b1, 64'h0,  0, 32'h0,  3,  9});
    tbl.push_back('{1,   1'b1, 64'h0,  0, 32'h0,  0, -1});
    tbl.push_back('{8,   1'b1, 64'h0,  0, 32'hE,  2,  5});
    tbl.push_back('{100, 1'b1, 64'h0,  0, 32'h0, 16, 61});
    tbl.push_back('{0,   1'b1, 64'h0, 20, 32'h0,  0, -1});
    tbl.push_back('{2,   1'b1, 64'h0,  0, 32'h0,  1,  1});
    tbl.push_back('{5,   1'b1, 64'h0, 30, 32'h0,  1,  1});
    tbl.push_back('{6,   1'b1, 64'h0, 30, 32'h0,  2,  5});
    tbl.push_back('{64,  1'b1, 64'h0, 40, 32'h0, 16, 61});
    tbl.push_back('{127, 1'b1, 64'h0, 25, 32'h0, 16, 61});
    tbl.push_back('{10,  1'b0, 64'h22, 0, 32'h0,  3,  9});
    tbl.push_back('{10,  1'b1, 64'h22, 0, 32'h0,  3,  9});

    foreach (tbl[i]) begin
      run_instr(tbl[i].vl, tbl[i].vm, tbl[i].mask, tbl[i].stall, tbl[i].hold, n, last);
      check($sformatf("tbl%0d_count", i), n, tbl[i].exp_n);
      check($sformatf("tbl%0d_last_elem", i), last, tbl[i].exp_last);
    end

    // Reset one cycle after the elem-5 handshake discards the instruction.
    in_valid = 1'b1;
    in_vl    = VL_W'(20);
    step();
    in_valid  = 1'b0;
    uop_ready = 1'b1;
    check("rst_seq_elem1", uop_elem, 1);
    step();
    check("rst_seq_elem5", uop_elem, 5);
    step();
    reset     = 1'b1;
    uop_ready = 1'b0;
    step();
    reset = 1'b0;
    check("rst_seq_valid", uop_valid, 0);
    check("rst_seq_in_ready", in_ready, 1);
    check("rst_seq_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_seq_no_done", done, 0);
    end
    run_instr(10, 1'b1, 64'h0, 0, 32'h0, n, last);
    check("rst_seq_restart_count", n, 3);

    for (int r = 0; r < 25; r++) begin
      int vl;
      vl = int'($urandom_range(0, 127));
      run_instr(vl, 1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 60)), 32'h0,
                n, last);
      check("rand_count", n, exp_count(vl));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
